// File: rtl/wr_port_40x64b_8_arbiter_if.sv
// Write-port request/grant bundle between eight producers, the arbiter and the 8:1 register-file mux.
// The slave modport is the arbiter's view; the master modport is the producer/mux side.
interface wr_port_40x64b_8_arbiter_if;
  logic [7:0]   req_wr_en;
  logic [47:0]  req_wr_addr;
  logic [511:0] req_wr_data;
  logic [7:0]   req_ready;
  logic [7:0]   select;
  logic [7:0]   out_wr_en;
  logic [47:0]  out_wr_addr;
  logic [511:0] out_wr_data;
  logic         addr_err;
  logic         busy;

  modport slave (
    input  req_wr_en, req_wr_addr, req_wr_data,
    output req_ready, select, out_wr_en, out_wr_addr, out_wr_data, addr_err, busy
  );

  modport master (
    output req_wr_en, req_wr_addr, req_wr_data,
    input  req_ready, select, out_wr_en, out_wr_addr, out_wr_data, addr_err, busy
  );
endinterface

// File: rtl/wr_port_40x64b_8_arbiter.sv
// Eight single-entry write slots, round-robin granted onto a one-hot mux select; accepted writes are visible the next cycle.
// Backpressure: req_ready[i] drops while slot i is full and not granted, and is held low during reset.
module wr_port_40x64b_8_arbiter (
  input  logic                            clk,
  input  logic                            rst_n,
  wr_port_40x64b_8_arbiter_if.slave       bus
);

  logic [7:0]  slot_valid;
  logic [5:0]  slot_addr [8];
  logic [63:0] slot_data [8];
  logic [2:0]  rr_ptr;
  logic        addr_err_q;

  logic        grant_vld;
  logic [2:0]  grant_idx;
  logic [2:0]  scan_idx;
  logic [7:0]  select_int;
  logic [7:0]  ready_int;
  logic [7:0]  accept;
  logic [7:0]  bad_addr;

  // First valid slot at or after rr_ptr, wrapping 7 -> 0.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = rr_ptr;
    scan_idx  = rr_ptr;
    for (int k = 0; k < 8; k++) begin
      scan_idx = rr_ptr + 3'(k);
      if (!grant_vld && slot_valid[scan_idx]) begin
        grant_vld = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  assign select_int = grant_vld ? (8'h01 << grant_idx) : 8'h00;

  // A granted slot drains this cycle, so it may be refilled at the same edge.
  assign ready_int = {8{rst_n}} & (~slot_valid | select_int);

  always_comb begin
    accept   = 8'h00;
    bad_addr = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (bus.req_wr_en[i] && ready_int[i]) begin
        if (bus.req_wr_addr[6*i +: 6] < 6'd40) accept[i]   = 1'b1;
        else                                   bad_addr[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_valid <= 8'h00;
      rr_ptr     <= 3'd0;
      addr_err_q <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        slot_addr[i] <= 6'd0;
        slot_data[i] <= 64'd0;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (accept[i]) begin
          slot_valid[i] <= 1'b1;
          slot_addr[i]  <= bus.req_wr_addr[6*i +: 6];
          slot_data[i]  <= bus.req_wr_data[64*i +: 64];
        end else if (select_int[i]) begin
          slot_valid[i] <= 1'b0;
        end
      end
      if (|bad_addr) addr_err_q <= 1'b1;
      if (grant_vld) rr_ptr <= grant_idx + 3'd1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_pack
      assign bus.out_wr_addr[6*gi +: 6]   = slot_addr[gi];
      assign bus.out_wr_data[64*gi +: 64] = slot_data[gi];
    end
  endgenerate

  assign bus.out_wr_en = slot_valid;
  assign bus.select    = select_int;
  assign bus.req_ready = ready_int;
  assign bus.addr_err  = addr_err_q;
  assign bus.busy      = |slot_valid;

endmodule

// File: tb/tb_wr_port_40x64b_8_arbiter.sv
// Directed bench for the write-port arbiter: reset, single write, full fan-in, streaming, bad address, two-port fairness.
module tb_wr_port_40x64b_8_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  wr_port_40x64b_8_arbiter_if bus ();

  wr_port_40x64b_8_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic [5:0] a, input logic [63:0] d);
    bus.req_wr_addr[6*p +: 6]   = a;
    bus.req_wr_data[64*p +: 64] = d;
  endtask

  logic [7:0] prev_sel;

  initial begin
    bus.req_wr_en   = 8'hFF;
    bus.req_wr_addr = '0;
    bus.req_wr_data = '0;
    for (int i = 0; i < 8; i++) set_port(i, 6'(i), {32'hDEAD_BEEF, 32'(i)});

    // Two reset edges with every producer posting.
    tick();
    check("rst_ready_1", 64'(bus.req_ready), 64'h00);
    tick();
    check("rst_ready_2", 64'(bus.req_ready), 64'h00);
    check("rst_select", 64'(bus.select), 64'h00);
    check("rst_busy", 64'(bus.busy), 64'h0);
    check("rst_addr_err", 64'(bus.addr_err), 64'h0);
    rst_n = 1'b1;
    #1;
    check("rel_select", 64'(bus.select), 64'h00);
    check("rel_out_wr_en", 64'(bus.out_wr_en), 64'h00);
    check("rel_busy", 64'(bus.busy), 64'h0);
    check("rel_ready", 64'(bus.req_ready), 64'hFF);

    // All eight accepted at one edge, granted 0..7 in order.
    tick();
    bus.req_wr_en = 8'h00;
    check("all_out_wr_en", 64'(bus.out_wr_en), 64'hFF);
    for (int g = 0; g < 8; g++) begin
      check($sformatf("all_select_%0d", g), 64'(bus.select), 64'(8'h01 << g));
      check($sformatf("all_ready_%0d", g), 64'(bus.req_ready), 64'((16'h1 << (g + 1)) - 16'h1));
      check($sformatf("all_addr_%0d", g), 64'(bus.out_wr_addr[6*g +: 6]), 64'(g));
      check($sformatf("all_data_%0d", g), bus.out_wr_data[64*g +: 64], {32'hDEAD_BEEF, 32'(g)});
      tick();
    end
    check("all_done_select", 64'(bus.select), 64'h00);
    check("all_done_busy", 64'(bus.busy), 64'h0);

    // Single write on port 3.
    set_port(3, 6'd5, 64'hDEAD_BEEF_0000_0003);
    bus.req_wr_en = 8'h08;
    tick();
    bus.req_wr_en = 8'h00;
    check("one_select", 64'(bus.select), 64'h08);
    check("one_out_wr_en", 64'(bus.out_wr_en), 64'h08);
    check("one_addr", 64'(bus.out_wr_addr[18 +: 6]), 64'd5);
    check("one_data", bus.out_wr_data[192 +: 64], 64'hDEAD_BEEF_0000_0003);
    tick();
    check("one_drained_select", 64'(bus.select), 64'h00);
    check("one_drained_en", 64'(bus.out_wr_en), 64'h00);

    // Port 2 streams addresses 0..9 back to back.
    set_port(2, 6'd0, 64'h2000);
    bus.req_wr_en = 8'h04;
    for (int k = 0; k < 10; k++) begin
      tick();
      check($sformatf("strm_select_%0d", k), 64'(bus.select), 64'h04);
      check($sformatf("strm_addr_%0d", k), 64'(bus.out_wr_addr[12 +: 6]), 64'(k));
      check($sformatf("strm_ready_%0d", k), 64'(bus.req_ready[2]), 64'h1);
      if (k < 9) set_port(2, 6'(k + 1), 64'h2000 + 64'(k + 1));
      else bus.req_wr_en = 8'h00;
    end
    tick();
    check("strm_end_select", 64'(bus.select), 64'h00);

    // Out-of-range address on port 1 is dropped and flagged.
    set_port(1, 6'd40, 64'h1111);
    bus.req_wr_en = 8'h02;
    #1;
    check("bad_ready", 64'(bus.req_ready[1]), 64'h1);
    tick();
    bus.req_wr_en = 8'h00;
    check("bad_addr_err", 64'(bus.addr_err), 64'h1);
    check("bad_select", 64'(bus.select), 64'h00);
    check("bad_busy", 64'(bus.busy), 64'h0);
    tick();
    tick();
    check("bad_sticky", 64'(bus.addr_err), 64'h1);

    // Ports 0 and 7 contend continuously; grants must alternate.
    set_port(0, 6'd10, 64'hA0);
    set_port(7, 6'd39, 64'hA7);
    bus.req_wr_en = 8'h81;
    tick();
    prev_sel = 8'h00;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("fair_select_%0d", k), 64'(bus.select), (k % 2 == 0) ? 64'h80 : 64'h01);
      check($sformatf("fair_no_repeat_%0d", k), 64'(bus.select == prev_sel), 64'h0);
      prev_sel = bus.select;
      tick();
    end
    check("fair_addr_err_held", 64'(bus.addr_err), 64'h1);

    // Reset mid-operation discards pending slots and clears the error flag.
    rst_n = 1'b0;
    tick();
    check("mid_rst_en", 64'(bus.out_wr_en), 64'h00);
    check("mid_rst_select", 64'(bus.select), 64'h00);
    check("mid_rst_ready", 64'(bus.req_ready), 64'h00);
    check("mid_rst_addr_err", 64'(bus.addr_err), 64'h0);
    check("mid_rst_addr", 64'(bus.out_wr_addr), 64'h0);
    bus.req_wr_en = 8'h00;
    rst_n = 1'b1;
    tick();
    check("post_rst_busy", 64'(bus.busy), 64'h0);
    check("post_rst_select", 64'(bus.select), 64'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
